// File: rtl/align_s2p_stream.sv
// Serial-to-parallel width converter: packs REG_NUM narrow beats into one wide word,
// with early close on idata_last (partial word plus lane keep mask).
module align_s2p_stream #(
    parameter int IDATA_BIT = 64,
    parameter int ODATA_BIT = 256,
    parameter int MSB_FIRST = 0,
    localparam int REG_NUM  = ODATA_BIT / IDATA_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDATA_BIT-1:0] idata,
    input  logic                 idata_valid,
    input  logic                 idata_last,
    output logic                 idata_ready,
    output logic [ODATA_BIT-1:0] odata,
    output logic [REG_NUM-1:0]   odata_keep,
    output logic                 odata_last,
    output logic                 odata_valid,
    input  logic                 odata_ready
);

    localparam int CNT_W = $clog2(REG_NUM);

    // Handshake: a beat moves on a clock edge where idata_valid && idata_ready,
    // a word moves where odata_valid && odata_ready; the sender holds its payload
    // until then, and idata_last has no meaning unless idata_valid is high.

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ODATA_BIT-1:0] buf_data;
    logic [REG_NUM-1:0]   buf_keep;
    logic                 pend_last;

    logic                 in_xfer;
    logic                 out_xfer;
    logic                 slot_free;
    logic                 complete;
    logic [CNT_W-1:0]     lane;
    logic [ODATA_BIT-1:0] word_data;
    logic [REG_NUM-1:0]   word_keep;

    assign in_xfer   = idata_valid && idata_ready;
    assign out_xfer  = odata_valid && odata_ready;
    assign slot_free = !odata_valid || odata_ready;
    assign complete  = (cnt == CNT_W'(REG_NUM - 1)) || idata_last;

    // Collect buffer with the incoming beat merged in, i.e. the word as it
    // would look if this beat closed it.
    always_comb begin
        lane      = (MSB_FIRST != 0) ? (CNT_W'(REG_NUM - 1) - cnt) : cnt;
        word_data = buf_data;
        word_keep = buf_keep;
        word_data[lane*IDATA_BIT +: IDATA_BIT] = idata;
        word_keep[lane] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= COLLECT;
            cnt         <= '0;
            buf_data    <= '0;
            buf_keep    <= '0;
            pend_last   <= 1'b0;
            idata_ready <= 1'b1;
            odata       <= '0;
            odata_keep  <= '0;
            odata_last  <= 1'b0;
            odata_valid <= 1'b0;
        end else begin
            // Drained slot empties unless a new word reloads it below.
            if (out_xfer) begin
                odata_valid <= 1'b0;
            end
            case (state)
                COLLECT: begin
                    if (in_xfer) begin
                        if (complete) begin
                            cnt <= '0;
                            if (slot_free) begin
                                odata       <= word_data;
                                odata_keep  <= word_keep;
                                odata_last  <= idata_last;
                                odata_valid <= 1'b1;
                                buf_data    <= '0;
                                buf_keep    <= '0;
                            end else begin
                                buf_data    <= word_data;
                                buf_keep    <= word_keep;
                                pend_last   <= idata_last;
                                state       <= PENDING;
                                idata_ready <= 1'b0;
                            end
                        end else begin
                            buf_data <= word_data;
                            buf_keep <= word_keep;
                            cnt      <= cnt + CNT_W'(1);
                        end
                    end
                end
                PENDING: begin
                    if (out_xfer) begin
                        odata       <= buf_data;
                        odata_keep  <= buf_keep;
                        odata_last  <= pend_last;
                        odata_valid <= 1'b1;
                        buf_data    <= '0;
                        buf_keep    <= '0;
                        pend_last   <= 1'b0;
                        state       <= COLLECT;
                        idata_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_align_s2p_stream.sv
// Bench for align_s2p_stream: LSB-first and MSB-first instances share one stimulus
// stream and are checked every cycle against a queue-based word model.
module tb_align_s2p_stream;

    localparam int IW = 64;
    localparam int OW = 256;
    localparam int R  = OW / IW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] idata = '0;
    logic          idata_valid = 1'b0;
    logic          idata_last = 1'b0;
    logic          odata_ready = 1'b0;

    logic          idata_ready, idata_ready_m;
    logic [OW-1:0] odata, odata_m;
    logic [R-1:0]  odata_keep, odata_keep_m;
    logic          odata_last, odata_last_m;
    logic          odata_valid, odata_valid_m;

    int tests = 0;
    int fails = 0;

    align_s2p_stream #(.IDATA_BIT(IW), .ODATA_BIT(OW), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .idata(idata), .idata_valid(idata_valid),
        .idata_last(idata_last), .idata_ready(idata_ready), .odata(odata),
        .odata_keep(odata_keep), .odata_last(odata_last), .odata_valid(odata_valid),
        .odata_ready(odata_ready)
    );

    align_s2p_stream #(.IDATA_BIT(IW), .ODATA_BIT(OW), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .idata(idata), .idata_valid(idata_valid),
        .idata_last(idata_last), .idata_ready(idata_ready_m), .odata(odata_m),
        .odata_keep(odata_keep_m), .odata_last(odata_last_m), .odata_valid(odata_valid_m),
        .odata_ready(odata_ready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Beats of the word being gathered, and the queue of whole words that are
    // inside the block (output slot first). At most two words fit inside.
    logic [IW-1:0] cur_q[$];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_m_q[$];
    logic [R-1:0]  keep_q[$];
    logic [R-1:0]  keep_m_q[$];
    logic          last_q[$];
    bit            started = 1'b0;
    bit            in_x, out_x;

    task automatic push_word(input logic lst);
        logic [OW-1:0] w, wm;
        logic [R-1:0]  k, km;
        w = '0; wm = '0; k = '0; km = '0;
        for (int i = 0; i < cur_q.size(); i++) begin
            w[i*IW +: IW]       = cur_q[i];
            wm[(R-1-i)*IW +: IW] = cur_q[i];
            k[i]       = 1'b1;
            km[R-1-i]  = 1'b1;
        end
        exp_q.push_back(w);
        exp_m_q.push_back(wm);
        keep_q.push_back(k);
        keep_m_q.push_back(km);
        last_q.push_back(lst);
        cur_q.delete();
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst) begin
            cur_q.delete(); exp_q.delete(); exp_m_q.delete();
            keep_q.delete(); keep_m_q.delete(); last_q.delete();
        end else begin
            in_x  = idata_valid && (exp_q.size() < 2);
            out_x = (exp_q.size() > 0) && odata_ready;
            if (out_x) begin
                void'(exp_q.pop_front()); void'(exp_m_q.pop_front());
                void'(keep_q.pop_front()); void'(keep_m_q.pop_front());
                void'(last_q.pop_front());
            end
            if (in_x) begin
                cur_q.push_back(idata);
                if (cur_q.size() == R || idata_last) push_word(idata_last);
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("idata_ready", idata_ready, exp_q.size() < 2);
            check("idata_ready_m", idata_ready_m, exp_q.size() < 2);
            check("odata_valid", odata_valid, exp_q.size() > 0);
            check("odata_valid_m", odata_valid_m, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("odata", odata, exp_q[0]);
                check("odata_keep", odata_keep, keep_q[0]);
                check("odata_last", odata_last, last_q[0]);
                check("odata_m", odata_m, exp_m_q[0]);
                check("odata_keep_m", odata_keep_m, keep_m_q[0]);
                check("odata_last_m", odata_last_m, last_q[0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [IW-1:0] d, input logic l, input logic v);
        idata = d; idata_last = l; idata_valid = v;
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] a, b, c, d, e, w, x, y, z;
    logic [IW-1:0] s[8];
    logic [IW-1:0] z64;

    initial begin
        a = 64'hA000_0000_0000_00A1; b = 64'hB000_0000_0000_00B2;
        c = 64'hC000_0000_0000_00C3; d = 64'hD000_0000_0000_00D4;
        e = 64'hE000_0000_0000_00E5; w = 64'h1111_0000_0000_0001;
        x = 64'h2222_0000_0000_0002; y = 64'h3333_0000_0000_0003;
        z = 64'h4444_0000_0000_0004; z64 = '0;
        for (int i = 0; i < 8; i++) s[i] = 64'h5000_0000_0000_0000 + 64'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_odata", odata, '0);
        check("rst_keep", odata_keep, '0);
        check("rst_valid", odata_valid, 1'b0);
        check("rst_ready", idata_ready, 1'b1);
        rst = 1'b1;

        // Full word, no backpressure
        odata_ready = 1'b1;
        drive(a, 0, 1); drive(b, 0, 1); drive(c, 0, 1); drive(d, 0, 1);
        check("full_data", odata, {d, c, b, a});
        check("full_keep", odata_keep, 4'b1111);
        check("full_last", odata_last, 1'b0);
        check("full_valid", odata_valid, 1'b1);
        drive(z64, 0, 0);
        check("full_valid_1cyc", odata_valid, 1'b0);

        // Partial word closed by last, then next beat lands in lane 0
        drive(a, 0, 1); drive(b, 1, 1);
        check("part_data", odata, {z64, z64, b, a});
        check("part_keep", odata_keep, 4'b0011);
        check("part_last", odata_last, 1'b1);
        check("part_data_m", odata_m, {a, b, z64, z64});
        check("part_keep_m", odata_keep_m, 4'b1100);
        drive(e, 1, 1);
        check("next_lane0", odata, {z64, z64, z64, e});
        check("next_keep", odata_keep, 4'b0001);
        drive(z64, 0, 0);

        // Sustained backpressure: 8 beats absorbed, then stall
        odata_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(s[i], 0, 1);
        check("stall_ready", idata_ready, 1'b0);
        check("stall_hold", odata, {s[3], s[2], s[1], s[0]});
        drive(z64, 0, 0);
        check("stall_hold2", odata, {s[3], s[2], s[1], s[0]});
        odata_ready = 1'b1;
        drive(z64, 0, 0);
        check("word2_data", odata, {s[7], s[6], s[5], s[4]});
        check("word2_valid", odata_valid, 1'b1);
        check("ready_back", idata_ready, 1'b1);
        drive(z64, 0, 0); drive(z64, 0, 0);

        // Drain and reload on the same edge
        odata_ready = 1'b0;
        for (int i = 0; i < 7; i++) drive(s[i], 0, 1);
        odata_ready = 1'b1;
        drive(s[7], 0, 1);
        check("b2b_ready", idata_ready, 1'b1);
        check("b2b_valid", odata_valid, 1'b1);
        check("b2b_data", odata, {s[7], s[6], s[5], s[4]});
        drive(z64, 0, 0);

        // Reset mid-word discards partial data
        drive(a, 0, 1); drive(b, 0, 1);
        rst = 1'b0;
        drive(z64, 0, 0);
        rst = 1'b1;
        drive(w, 0, 1); drive(x, 0, 1); drive(y, 0, 1); drive(z, 0, 1);
        check("rstmid_data", odata, {z, y, x, w});
        check("rstmid_keep", odata_keep, 4'b1111);
        drive(z64, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            odata_ready = ((i % 200) < 40) ? 1'b0 : ($urandom_range(0, 9) < 6);
            drive({$urandom, $urandom}, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
        end

        // Drain with a bounded wait
        odata_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) drive(z64, 0, 0);
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
